// File: rtl/acc_core_param_if.sv
// Host-side bus of acc_core_param: program load port, run handshake and output channels.
interface acc_core_param_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int OUT_CH = 2
);
  localparam int IW = 4 + DATA_W;

  logic                     run;
  logic                     prog_we;
  logic [PC_W-1:0]          prog_addr;
  logic [IW-1:0]            prog_data;
  logic [OUT_CH*DATA_W-1:0] out_data;
  logic [OUT_CH-1:0]        out_valid;
  logic                     busy;
  logic                     halted;
  logic [PC_W-1:0]          pc_dbg;

  modport master (
    output run, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, busy, halted, pc_dbg
  );

  modport slave (
    input  run, prog_we, prog_addr, prog_data,
    output out_data, out_valid, busy, halted, pc_dbg
  );
endinterface

// File: rtl/acc_core_param.sv
// Parametrised accumulator core: loadable program RAM, C/Z flags, branches, multi-channel OUT.
// Define ACC_CORE_MUL_EN to turn opcode B into a single-cycle MUL; otherwise B is a NOP.
module acc_core_param #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int OUT_CH = 2
)(
  input  logic           clk,
  input  logic           rst,
  acc_core_param_if.slave bus
);
  localparam int IW = 4 + DATA_W;

  localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4,
                         OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                         OP_OUT = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hC, OP_JC  = 4'hD,
                         OP_HLT = 4'hF;
`ifdef ACC_CORE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'hB;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  state_e                       state, state_nx;
  logic [IW-1:0]                mem [2**PC_W];
  logic [IW-1:0]                ir;
  logic [PC_W-1:0]              pc, pc_nx;
  logic [DATA_W-1:0]            acc, acc_nx;
  logic                         z_flag, z_nx, c_flag, c_nx, wr_acc;
  logic [OUT_CH-1:0][DATA_W-1:0] od, od_nx;
  logic [OUT_CH-1:0]            ov, ov_nx;
  logic [3:0]                   op;
  logic [DATA_W-1:0]            imm;
  logic [PC_W-1:0]              tgt;
  logic [DATA_W:0]              sum;

  assign op  = ir[IW-1:DATA_W];
  assign imm = ir[DATA_W-1:0];
  assign tgt = imm[PC_W-1:0];

`ifdef ACC_CORE_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = acc * imm;
`endif

  // Program RAM and instruction register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    if (state == S_FETCH) ir <= mem[pc];
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    acc_nx   = acc;
    z_nx     = z_flag;
    c_nx     = c_flag;
    od_nx    = od;
    ov_nx    = '0;
    wr_acc   = 1'b0;
    sum      = '0;
    unique case (state)
      S_IDLE:  if (bus.run) state_nx = S_FETCH;
      S_FETCH: state_nx = S_EXEC;
      S_EXEC: begin
        pc_nx    = pc + 1'b1;
        state_nx = bus.run ? S_FETCH : S_IDLE;
        case (op)
          OP_LDI: begin acc_nx = imm; wr_acc = 1'b1; end
          OP_ADD: begin
            sum = {1'b0, acc} + {1'b0, imm};
            {c_nx, acc_nx} = sum;
            wr_acc = 1'b1;
          end
          OP_SUB: begin
            sum = {1'b0, acc} - {1'b0, imm};
            {c_nx, acc_nx} = sum;
            wr_acc = 1'b1;
          end
          OP_AND: begin acc_nx = acc & imm; wr_acc = 1'b1; end
          OP_OR:  begin acc_nx = acc | imm; wr_acc = 1'b1; end
          OP_XOR: begin acc_nx = acc ^ imm; wr_acc = 1'b1; end
          OP_SHL: begin {c_nx, acc_nx} = {acc, 1'b0}; wr_acc = 1'b1; end
          OP_SHR: begin {acc_nx, c_nx} = {1'b0, acc}; wr_acc = 1'b1; end
          OP_OUT: begin
            for (int k = 0; k < OUT_CH; k++) begin
              if (32'(imm) % OUT_CH == k) begin
                od_nx[k] = acc;
                ov_nx[k] = 1'b1;
              end
            end
          end
          OP_JMP: pc_nx = tgt;
`ifdef ACC_CORE_MUL_EN
          OP_MUL: begin
            acc_nx = prod[DATA_W-1:0];
            c_nx   = |prod[2*DATA_W-1:DATA_W];
            wr_acc = 1'b1;
          end
`endif
          OP_JZ:  if (z_flag) pc_nx = tgt;
          OP_JC:  if (c_flag) pc_nx = tgt;
          OP_HLT: state_nx = S_HALT;
          default: ;
        endcase
        if (wr_acc) z_nx = (acc_nx == '0);
      end
      S_HALT: if (!bus.run) begin
        state_nx = S_IDLE;
        pc_nx    = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The strobe is registered with the channel data so both are seen on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      acc    <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      od     <= '0;
      ov     <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      acc    <= acc_nx;
      z_flag <= z_nx;
      c_flag <= c_nx;
      od     <= od_nx;
      ov     <= ov_nx;
    end
  end

  assign bus.out_data  = od;
  assign bus.out_valid = ov;
  assign bus.busy      = (state == S_FETCH) || (state == S_EXEC);
  assign bus.halted    = (state == S_HALT);
  assign bus.pc_dbg    = pc;
endmodule

// File: tb/tb_acc_core_param.sv
// Directed bench for acc_core_param: hand-assembled programs with hand-computed results.
module tb_acc_core_param;
  localparam int DATA_W = 8;
  localparam int PC_W   = 4;
  localparam int OUT_CH = 2;
  localparam int IW     = 4 + DATA_W;

  logic clk, rst;
  int   checks = 0, errors = 0;
  int   s0, s1, bcyc;
  logic [IW-1:0] img [16];

  acc_core_param_if #(.DATA_W(DATA_W), .PC_W(PC_W), .OUT_CH(OUT_CH)) bus ();

  acc_core_param #(.DATA_W(DATA_W), .PC_W(PC_W), .OUT_CH(OUT_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_img();
    for (int i = 0; i < 16; i++) img[i] = ins(4'h0, 8'h00);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = PC_W'(i);
      bus.prog_data = img[i];
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  // Runs until HALT (bounded), counting strobes and busy cycles, then returns to IDLE.
  task automatic run_prog(input string tag, input int maxc);
    int n;
    n = 0; s0 = 0; s1 = 0; bcyc = 0;
    bus.run = 1'b1;
    while (!bus.halted && n < maxc) begin
      tick();
      n++;
      if (bus.out_valid[0]) s0++;
      if (bus.out_valid[1]) s1++;
      if (bus.busy) bcyc++;
    end
    chk({tag, "_halted"}, 32'(bus.halted), 32'd1);
    bus.run = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    tick(); tick();
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_halted",    32'(bus.halted),    32'h0);
    chk("rst_pc",        32'(bus.pc_dbg),    32'h0);
    rst = 1'b0;
    tick();

    // A: 0x0F + 0xF5 = 0x104 -> ch1 = 0x04, C = 1
    clr_img();
    img[0] = ins(4'h1, 8'h0F); img[1] = ins(4'h2, 8'hF5);
    img[2] = ins(4'h9, 8'h01); img[3] = ins(4'hF, 8'h00);
    load_prog();
    run_prog("A", 40);
    chk("A_busy_cycles", 32'(bcyc), 32'd8);
    chk("A_strobe_ch1",  32'(s1), 32'd1);
    chk("A_strobe_ch0",  32'(s0), 32'd0);
    chk("A_out_data",    32'(bus.out_data), 32'h0400);
    chk("A_acc",         32'(dut.acc), 32'h04);
    chk("A_carry",       32'(dut.c_flag), 32'd1);
    chk("A_zero",        32'(dut.z_flag), 32'd0);
    chk("A_idle_halted", 32'(bus.halted), 32'd0);
    chk("A_idle_pc",     32'(bus.pc_dbg), 32'd0);

    // B: countdown loop, one OUT of zero to ch0, ch1 holds
    clr_img();
    img[0] = ins(4'h1, 8'h03); img[1] = ins(4'h3, 8'h01); img[2] = ins(4'hC, 8'h04);
    img[3] = ins(4'hA, 8'h01); img[4] = ins(4'h9, 8'h00); img[5] = ins(4'hF, 8'h00);
    load_prog();
    run_prog("B", 100);
    chk("B_strobe_ch0", 32'(s0), 32'd1);
    chk("B_strobe_ch1", 32'(s1), 32'd0);
    chk("B_out_data",   32'(bus.out_data), 32'h0400);
    chk("B_zero",       32'(dut.z_flag), 32'd1);
    chk("B_carry",      32'(dut.c_flag), 32'd0);

    // C: shifts, logic ops, borrow and a taken JC that skips an OUT
    clr_img();
    img[0]  = ins(4'h1, 8'h81); img[1]  = ins(4'h7, 8'h00); img[2]  = ins(4'h9, 8'h00);
    img[3]  = ins(4'h8, 8'h00); img[4]  = ins(4'h5, 8'hF0); img[5]  = ins(4'h6, 8'h0F);
    img[6]  = ins(4'h4, 8'h3C); img[7]  = ins(4'h9, 8'h01); img[8]  = ins(4'h3, 8'h3D);
    img[9]  = ins(4'hD, 8'h0B); img[10] = ins(4'h9, 8'h00); img[11] = ins(4'h9, 8'h01);
    img[12] = ins(4'hF, 8'h00);
    load_prog();
    run_prog("C", 100);
    chk("C_strobe_ch0", 32'(s0), 32'd1);
    chk("C_strobe_ch1", 32'(s1), 32'd2);
    chk("C_out_data",   32'(bus.out_data), 32'hFF02);
    chk("C_acc",        32'(dut.acc), 32'hFF);
    chk("C_carry",      32'(dut.c_flag), 32'd1);

    // E: async reset in the middle of a running loop
    clr_img();
    img[0] = ins(4'h1, 8'h5A); img[1] = ins(4'h9, 8'h00); img[2] = ins(4'hA, 8'h01);
    load_prog();
    bus.run = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("E_run_ch0", 32'(bus.out_data[7:0]), 32'h5A);
    chk("E_run_acc", 32'(dut.acc), 32'h5A);
    rst = 1'b1;
    #1;
    chk("E_rst_out_data",  32'(bus.out_data),  32'h0);
    chk("E_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("E_rst_busy",      32'(bus.busy),      32'h0);
    chk("E_rst_halted",    32'(bus.halted),    32'h0);
    chk("E_rst_pc",        32'(bus.pc_dbg),    32'h0);
    chk("E_rst_acc",       32'(dut.acc),       32'h0);
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // D: NOPs then OUT 0 at the last address; pc wraps and OUT fires twice
    clr_img();
    img[15] = ins(4'h9, 8'h00);
    load_prog();
    bus.run = 1'b1;
    s0 = 0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (bus.out_valid[0]) s0++;
      if (k == 31) chk("D_pc_top", 32'(bus.pc_dbg), 32'd15);
      if (k == 33) chk("D_pc_wrap", 32'(bus.pc_dbg), 32'd0);
    end
    chk("D_strobes", 32'(s0), 32'd2);
    bus.run = 1'b0;
    for (int k = 0; k < 5 && bus.busy; k++) tick();
    chk("D_stopped", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // F: pause mid-loop, patch program while idle, resume at held pc
    clr_img();
    img[0] = ins(4'h1, 8'h05); img[1] = ins(4'h3, 8'h01); img[2] = ins(4'hC, 8'h04);
    img[3] = ins(4'hA, 8'h01); img[4] = ins(4'h9, 8'h00); img[5] = ins(4'hF, 8'h00);
    load_prog();
    bus.run = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    bus.run = 1'b0;
    tick();
    chk("F_pause_busy", 32'(bus.busy), 32'd0);
    chk("F_pause_pc",   32'(bus.pc_dbg), 32'd3);
    tick(); tick();
    chk("F_hold_pc",  32'(bus.pc_dbg), 32'd3);
    chk("F_hold_acc", 32'(dut.acc), 32'h04);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd4; bus.prog_data = ins(4'h9, 8'h01);
    bus.run = 1'b1;
    tick();
    chk("F_resume_busy", 32'(bus.busy), 32'd1);
    chk("F_resume_pc",   32'(bus.pc_dbg), 32'd3);
    bus.prog_addr = 4'd5; bus.prog_data = ins(4'h0, 8'h00);
    run_prog("F", 100);
    bus.prog_we = 1'b0;
    chk("F_strobe_ch1", 32'(s1), 32'd1);
    chk("F_strobe_ch0", 32'(s0), 32'd0);
    chk("F_zero",       32'(dut.z_flag), 32'd1);

    // G: multiply (optional) with C preset to 1
    clr_img();
    img[0] = ins(4'h1, 8'hFF); img[1] = ins(4'h2, 8'h01); img[2] = ins(4'h1, 8'h12);
    img[3] = ins(4'hB, 8'h10); img[4] = ins(4'hF, 8'h00);
    load_prog();
    run_prog("G1", 60);
`ifdef ACC_CORE_MUL_EN
    chk("G1_acc", 32'(dut.acc), 32'h20);
`else
    chk("G1_acc", 32'(dut.acc), 32'h12);
`endif
    chk("G1_carry", 32'(dut.c_flag), 32'd1);
    chk("G1_zero",  32'(dut.z_flag), 32'd0);
    clr_img();
    img[0] = ins(4'h1, 8'h03); img[1] = ins(4'hB, 8'h05); img[2] = ins(4'hF, 8'h00);
    load_prog();
    run_prog("G2", 40);
`ifdef ACC_CORE_MUL_EN
    chk("G2_acc",   32'(dut.acc), 32'h0F);
    chk("G2_carry", 32'(dut.c_flag), 32'd0);
`else
    chk("G2_acc",   32'(dut.acc), 32'h03);
    chk("G2_carry", 32'(dut.c_flag), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
